// File: rtl/branch_predictor_gshare_pkg.sv
// Shared types and constants for the gshare branch predictor: BTB/resolve
// type encodings, PHT counter constants and the saturating counter update.
package branch_predictor_gshare_pkg;

   // Type reported on lookup; a return is reported as BTB_COND.
   typedef enum logic [1:0] {
      BTB_NONE = 2'd0,
      BTB_COND = 2'd1,
      BTB_JUMP = 2'd2,
      BTB_CALL = 2'd3
   } btb_type_t;

   // Type supplied by EX and stored verbatim in the BTB payload.
   typedef enum logic [1:0] {
      RES_COND = 2'd0,
      RES_JUMP = 2'd1,
      RES_CALL = 2'd2,
      RES_RET  = 2'd3
   } res_type_t;

   localparam logic [1:0] PHT_RESET  = 2'b01;
   localparam logic [1:0] PHT_THRESH = 2'b10;

   function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      nxt = ctr;
      if (taken && ctr != 2'b11)
         nxt = ctr + 2'b01;
      else if (!taken && ctr != 2'b00)
         nxt = ctr - 2'b01;
      return nxt;
   endfunction

   function automatic btb_type_t report_type(input logic [1:0] stored);
      btb_type_t t;
      case (stored)
         RES_JUMP: t = BTB_JUMP;
         RES_CALL: t = BTB_CALL;
         default:  t = BTB_COND;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/branch_predictor_gshare_ras_stack.sv
// Circular return address stack with a speculative push/pop port and a
// checkpoint-restore port that replays the resolving instruction's own action.
module branch_predictor_gshare_ras_stack
   import branch_predictor_gshare_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int RAS_PTR_W = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 spec_push,
   input  logic                 spec_pop,
   input  logic [DATA_W-1:0]    spec_data,
   input  logic                 rec_valid,
   input  logic                 rec_push,
   input  logic                 rec_pop,
   input  logic [RAS_PTR_W-1:0] rec_ptr,
   input  logic [DATA_W-1:0]    rec_data,
   output logic [RAS_PTR_W-1:0] ptr,
   output logic [DATA_W-1:0]    top
);

   localparam int RAS_N = 1 << RAS_PTR_W;
   localparam logic [RAS_PTR_W-1:0] ONE = RAS_PTR_W'(1);

   logic [DATA_W-1:0]    mem [RAS_N];
   logic [RAS_PTR_W-1:0] ptr_nxt;
   logic [RAS_PTR_W-1:0] wr_idx;
   logic [DATA_W-1:0]    wr_data;
   logic                 wr_en;

   // Restore wins over the speculative port: the fetch it belongs to is flushed.
   always_comb begin
      ptr_nxt = ptr;
      wr_en   = 1'b0;
      wr_idx  = ptr;
      wr_data = spec_data;
      if (rec_valid) begin
         ptr_nxt = rec_ptr;
         if (rec_push) begin
            wr_en   = 1'b1;
            wr_idx  = rec_ptr;
            wr_data = rec_data;
            ptr_nxt = rec_ptr + ONE;
         end else if (rec_pop) begin
            ptr_nxt = rec_ptr - ONE;
         end
      end else if (spec_push) begin
         wr_en   = 1'b1;
         ptr_nxt = ptr + ONE;
      end else if (spec_pop) begin
         ptr_nxt = ptr - ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= '0;
         for (int i = 0; i < RAS_N; i++)
            mem[i] <= '0;
      end else begin
         ptr <= ptr_nxt;
         if (wr_en)
            mem[wr_idx] <= wr_data;
      end
   end

   assign top = mem[ptr - ONE];

endmodule

// File: rtl/branch_predictor_gshare.sv
// Gshare direction predictor with direct-mapped BTB, speculative GHR and RAS;
// combinational IF lookup, EX training and checkpoint-based mispredict recovery.
module branch_predictor_gshare
   import branch_predictor_gshare_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int PHT_IDX_W = 10,
   parameter int GHR_W     = 8,
   parameter int BTB_IDX_W = 4,
   parameter int BTB_TAG_W = 10,
   parameter int RAS_PTR_W = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 if_valid,
   input  logic [DATA_W-1:0]    if_pc,
   output logic                 pred_taken,
   output logic [DATA_W-1:0]    pred_target,
   output logic [1:0]           pred_type,
   output logic [GHR_W-1:0]     pred_ghr,
   output logic [RAS_PTR_W-1:0] pred_ras_ptr,
   input  logic                 ex_valid,
   input  logic [DATA_W-1:0]    ex_pc,
   input  logic [1:0]           ex_type,
   input  logic                 ex_taken,
   input  logic [DATA_W-1:0]    ex_target,
   input  logic [GHR_W-1:0]     ex_ghr,
   input  logic [RAS_PTR_W-1:0] ex_ras_ptr,
   input  logic                 ex_mispredict
);

   localparam int PHT_N = 1 << PHT_IDX_W;
   localparam int BTB_N = 1 << BTB_IDX_W;

   logic [1:0]           pht [PHT_N];
   logic                 btb_valid [BTB_N];
   logic [BTB_TAG_W-1:0] btb_tag [BTB_N];
   logic [1:0]           btb_type [BTB_N];
   logic [DATA_W-1:0]    btb_tgt [BTB_N];

   logic [GHR_W-1:0]     ghr;
   logic [RAS_PTR_W-1:0] ras_ptr;
   logic [DATA_W-1:0]    ras_top;

   logic [PHT_IDX_W-1:0] if_pht_idx, ex_pht_idx;
   logic [BTB_IDX_W-1:0] if_btb_idx, ex_btb_idx;
   logic [BTB_TAG_W-1:0] if_tag, ex_tag;
   logic [DATA_W-1:0]    if_seq, ex_seq;
   logic [1:0]           if_ctr;
   logic [1:0]           if_rtype;
   logic                 if_hit;

   logic spec_en, spec_cond, spec_push, spec_pop;
   logic recover, ex_is_cond;

   // Only the index/tag slices of the PCs feed the tables.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{if_pc, ex_pc};

   assign if_pht_idx = if_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr);
   assign ex_pht_idx = ex_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ex_ghr);
   assign if_btb_idx = if_pc[BTB_IDX_W+1:2];
   assign ex_btb_idx = ex_pc[BTB_IDX_W+1:2];
   assign if_tag     = if_pc[BTB_IDX_W+BTB_TAG_W+1:BTB_IDX_W+2];
   assign ex_tag     = ex_pc[BTB_IDX_W+BTB_TAG_W+1:BTB_IDX_W+2];
   assign if_seq     = if_pc + DATA_W'(4);
   assign ex_seq     = ex_pc + DATA_W'(4);

   assign if_hit   = btb_valid[if_btb_idx] && (btb_tag[if_btb_idx] == if_tag);
   assign if_rtype = btb_type[if_btb_idx];
   assign if_ctr   = pht[if_pht_idx];

   always_comb begin
      pred_taken  = 1'b0;
      pred_target = if_seq;
      pred_type   = BTB_NONE;
      if (if_hit) begin
         pred_type = report_type(if_rtype);
         case (if_rtype)
            RES_COND: begin
               if (if_ctr >= PHT_THRESH) begin
                  pred_taken  = 1'b1;
                  pred_target = btb_tgt[if_btb_idx];
               end
            end
            RES_RET: begin
               pred_taken  = 1'b1;
               pred_target = ras_top;
            end
            default: begin
               pred_taken  = 1'b1;
               pred_target = btb_tgt[if_btb_idx];
            end
         endcase
      end
   end

   assign pred_ghr     = ghr;
   assign pred_ras_ptr = ras_ptr;

   assign spec_en    = if_valid && !ex_mispredict && if_hit;
   assign spec_cond  = spec_en && (if_rtype == RES_COND);
   assign spec_push  = spec_en && (if_rtype == RES_CALL);
   assign spec_pop   = spec_en && (if_rtype == RES_RET);
   assign recover    = ex_valid && ex_mispredict;
   assign ex_is_cond = (ex_type == RES_COND);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         ghr <= '0;
      else if (recover)
         ghr <= ex_is_cond ? {ex_ghr[GHR_W-2:0], ex_taken} : ex_ghr;
      else if (spec_cond)
         ghr <= {ghr[GHR_W-2:0], pred_taken};
   end

   // Training reads the pre-edge counter; a same-cycle lookup sees the old value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < PHT_N; i++)
            pht[i] <= PHT_RESET;
      end else if (ex_valid && ex_is_cond) begin
         pht[ex_pht_idx] <= sat_update(pht[ex_pht_idx], ex_taken);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < BTB_N; i++)
            btb_valid[i] <= 1'b0;
      end else if (ex_valid && ex_taken) begin
         btb_valid[ex_btb_idx] <= 1'b1;
      end
   end

   // Payload needs no reset; the valid bit qualifies it.
   always_ff @(posedge clk) begin
      if (ex_valid && ex_taken) begin
         btb_tag[ex_btb_idx]  <= ex_tag;
         btb_type[ex_btb_idx] <= ex_type;
         btb_tgt[ex_btb_idx]  <= ex_target;
      end
   end

   branch_predictor_gshare_ras_stack #(
      .DATA_W    (DATA_W),
      .RAS_PTR_W (RAS_PTR_W)
   ) ras_stack (
      .clk       (clk),
      .rst       (rst),
      .spec_push (spec_push),
      .spec_pop  (spec_pop),
      .spec_data (if_seq),
      .rec_valid (recover),
      .rec_push  (ex_type == RES_CALL),
      .rec_pop   (ex_type == RES_RET),
      .rec_ptr   (ex_ras_ptr),
      .rec_data  (ex_seq),
      .ptr       (ras_ptr),
      .top       (ras_top)
   );

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench for branch_predictor_gshare: reset, PHT training/saturation,
// speculative GHR, CALL/RET with RAS wrap, recovery priority and async reset.
module tb_branch_predictor_gshare;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic [1:0]  pred_type;
   logic [7:0]  pred_ghr;
   logic [1:0]  pred_ras_ptr;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [1:0]  ex_type;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic [7:0]  ex_ghr;
   logic [1:0]  ex_ras_ptr;
   logic        ex_mispredict;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   branch_predictor_gshare dut (
      .clk           (clk),
      .rst           (rst),
      .if_valid      (if_valid),
      .if_pc         (if_pc),
      .pred_taken    (pred_taken),
      .pred_target   (pred_target),
      .pred_type     (pred_type),
      .pred_ghr      (pred_ghr),
      .pred_ras_ptr  (pred_ras_ptr),
      .ex_valid      (ex_valid),
      .ex_pc         (ex_pc),
      .ex_type       (ex_type),
      .ex_taken      (ex_taken),
      .ex_target     (ex_target),
      .ex_ghr        (ex_ghr),
      .ex_ras_ptr    (ex_ras_ptr),
      .ex_mispredict (ex_mispredict)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [31:0] call_pcs [5];
      logic [31:0] ret_exp [5];
      call_pcs = '{32'h300, 32'h304, 32'h308, 32'h30C, 32'h314};
      ret_exp  = '{32'h318, 32'h310, 32'h30C, 32'h308, 32'h318};

      rst = 1'b0; if_valid = 1'b1; if_pc = 32'h100;
      ex_valid = 1'b0; ex_pc = '0; ex_type = 2'd0; ex_taken = 1'b0;
      ex_target = '0; ex_ghr = '0; ex_ras_ptr = '0; ex_mispredict = 1'b0;

      // reset values
      tick(); tick();
      chk("rst_taken", 32'(pred_taken), 32'h0);
      chk("rst_target", pred_target, 32'h104);
      chk("rst_type", 32'(pred_type), 32'h0);
      chk("rst_ghr", 32'(pred_ghr), 32'h0);
      chk("rst_ptr", 32'(pred_ras_ptr), 32'h0);
      rst = 1'b1;
      tick();
      chk("post_rst_taken", 32'(pred_taken), 32'h0);
      chk("post_rst_target", pred_target, 32'h104);

      // conditional training with mispredict recovery
      if_valid = 1'b0;
      ex_valid = 1'b1; ex_pc = 32'h200; ex_type = 2'd0; ex_taken = 1'b1;
      ex_target = 32'h180; ex_ghr = 8'h00; ex_ras_ptr = 2'd0; ex_mispredict = 1'b1;
      tick();
      ex_valid = 1'b0; ex_mispredict = 1'b0; if_pc = 32'h200;
      #1;
      chk("cond_ghr", 32'(pred_ghr), 32'h01);
      chk("cond_new_idx_taken", 32'(pred_taken), 32'h0);
      chk("cond_type", 32'(pred_type), 32'h1);
      chk("cond_nt_target", pred_target, 32'h204);
      ex_valid = 1'b1; ex_ghr = 8'h01;
      tick(); tick();
      ex_valid = 1'b0;
      #1;
      chk("cond_trained_taken", 32'(pred_taken), 32'h1);
      chk("cond_trained_target", pred_target, 32'h180);

      // speculative GHR shift of a taken prediction
      if_valid = 1'b1;
      tick();
      if_valid = 1'b0;
      #1;
      chk("spec_ghr_taken", 32'(pred_ghr), 32'h03);

      // saturation at 3, then decrement
      ex_valid = 1'b1; ex_pc = 32'h244; ex_type = 2'd0; ex_taken = 1'b1;
      ex_target = 32'h1F0; ex_ghr = 8'h03;
      repeat (5) tick();
      ex_valid = 1'b0; if_pc = 32'h244;
      #1;
      chk("sat5_taken", 32'(pred_taken), 32'h1);
      chk("sat5_target", pred_target, 32'h1F0);
      ex_valid = 1'b1; ex_taken = 1'b0;
      tick();
      ex_valid = 1'b0;
      #1;
      chk("sat_nt1_taken", 32'(pred_taken), 32'h1);
      chk("sat_nt1_target", pred_target, 32'h1F0);
      ex_valid = 1'b1;
      tick();
      ex_valid = 1'b0;
      #1;
      chk("sat_nt2_taken", 32'(pred_taken), 32'h0);
      chk("sat_nt2_target", pred_target, 32'h248);
      if_valid = 1'b1;
      tick();
      if_valid = 1'b0;
      #1;
      chk("spec_ghr_nt", 32'(pred_ghr), 32'h06);

      // CALL/RET training
      ex_valid = 1'b1; ex_taken = 1'b1; ex_mispredict = 1'b0;
      ex_type = 2'd2; ex_pc = 32'h300; ex_target = 32'h800; tick();
      ex_type = 2'd3; ex_pc = 32'h810; ex_target = 32'h304; tick();
      ex_type = 2'd2; ex_target = 32'h900;
      ex_pc = 32'h304; tick();
      ex_pc = 32'h308; tick();
      ex_pc = 32'h30C; tick();
      ex_pc = 32'h314; tick();
      ex_valid = 1'b0;
      if_pc = 32'h300;
      #1;
      chk("call_taken", 32'(pred_taken), 32'h1);
      chk("call_target", pred_target, 32'h800);
      chk("call_type", 32'(pred_type), 32'h3);
      if_valid = 1'b1;
      tick();
      if_valid = 1'b0;
      #1;
      chk("call_ptr", 32'(pred_ras_ptr), 32'h1);
      if_pc = 32'h810;
      #1;
      chk("ret_taken", 32'(pred_taken), 32'h1);
      chk("ret_target", pred_target, 32'h304);
      chk("ret_type", 32'(pred_type), 32'h1);
      if_valid = 1'b1;
      tick();
      if_valid = 1'b0;
      #1;
      chk("ret_ptr", 32'(pred_ras_ptr), 32'h0);

      // five nested calls into a depth-4 stack, then five returns
      if_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if_pc = call_pcs[i];
         tick();
      end
      if_valid = 1'b0;
      #1;
      chk("nest_ptr", 32'(pred_ras_ptr), 32'h1);
      if_pc = 32'h810; if_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("nest_ret%0d", i), pred_target, ret_exp[i]);
         tick();
      end
      if_valid = 1'b0;
      #1;
      chk("nest_ptr_end", 32'(pred_ras_ptr), 32'h0);

      // recovery beats a same-cycle speculative CALL push
      if_pc = 32'h300; if_valid = 1'b1;
      tick();
      #1;
      chk("prio_pre_ptr", 32'(pred_ras_ptr), 32'h1);
      ex_valid = 1'b1; ex_mispredict = 1'b1; ex_type = 2'd3; ex_pc = 32'h810;
      ex_target = 32'h304; ex_taken = 1'b1; ex_ghr = 8'h55; ex_ras_ptr = 2'd1;
      tick();
      ex_valid = 1'b0; ex_mispredict = 1'b0; if_valid = 1'b0;
      #1;
      chk("prio_ptr", 32'(pred_ras_ptr), 32'h0);
      chk("prio_ghr", 32'(pred_ghr), 32'h55);

      // CALL recovery replays its push at the checkpoint
      ex_valid = 1'b1; ex_mispredict = 1'b1; ex_type = 2'd2; ex_pc = 32'h500;
      ex_target = 32'h800; ex_taken = 1'b1; ex_ghr = 8'h55; ex_ras_ptr = 2'd2;
      tick();
      ex_valid = 1'b0; ex_mispredict = 1'b0; if_pc = 32'h810;
      #1;
      chk("rec_call_ptr", 32'(pred_ras_ptr), 32'h3);
      chk("rec_call_target", pred_target, 32'h504);

      // COND recovery appends actual direction to the checkpoint
      ex_valid = 1'b1; ex_mispredict = 1'b1; ex_type = 2'd0; ex_pc = 32'h500;
      ex_taken = 1'b0; ex_ghr = 8'h55; ex_ras_ptr = 2'd3;
      tick();
      ex_valid = 1'b0; ex_mispredict = 1'b0;
      #1;
      chk("rec_cond_ghr", 32'(pred_ghr), 32'hAA);
      chk("rec_cond_ptr", 32'(pred_ras_ptr), 32'h3);

      // asynchronous reset between clock edges
      #1;
      rst = 1'b0;
      #1;
      chk("arst_ghr", 32'(pred_ghr), 32'h0);
      chk("arst_ptr", 32'(pred_ras_ptr), 32'h0);
      chk("arst_taken", 32'(pred_taken), 32'h0);
      chk("arst_target", pred_target, 32'h814);
      chk("arst_type", 32'(pred_type), 32'h0);
      rst = 1'b1;
      tick();
      chk("arst_after_taken", 32'(pred_taken), 32'h0);
      chk("arst_after_type", 32'(pred_type), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
